// File: rtl/horner_poly_seq_if.sv
// Request/response bundle between a client and the Horner polynomial evaluator.
interface horner_poly_seq_if #(
  parameter int unsigned N   = 13,
  parameter int unsigned DEG = 3
);
  logic                   start_i;
  logic [N-1:0]           x_i;
  logic [(DEG+1)*N-1:0]   coef_i;
  logic                   busy_o;
  logic                   done_o;
  logic [N-1:0]           y_o;
  logic                   ovf_o;

  modport master (
    output start_i, x_i, coef_i,
    input  busy_o, done_o, y_o, ovf_o
  );

  modport slave (
    input  start_i, x_i, coef_i,
    output busy_o, done_o, y_o, ovf_o
  );
endinterface

// File: rtl/horner_poly_seq.sv
// Horner-scheme unsigned fixed-point polynomial evaluator driving an external pipelined multiplier.
// Define HORNER_ROUND_EN to round half-up at the fractional shift; otherwise the product is truncated.
module horner_poly_seq #(
  parameter int unsigned N       = 13,
  parameter int unsigned DEG     = 3,
  parameter int unsigned FRAC    = 10,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic              clkn_i,
  input  logic              rstn_i,
  horner_poly_seq_if.slave  req,
  output logic [N-1:0]      mul_a_o,
  output logic [N-1:0]      mul_b_o,
  input  logic [2*N-1:0]    mul_p_i
);

  localparam int unsigned KW = (DEG + 1 > 1) ? $clog2(DEG + 1) : 1;
  localparam int unsigned CW = (MUL_LAT + 1 > 1) ? $clog2(MUL_LAT + 1) : 1;
  localparam int unsigned TW = 2*N - FRAC + 1;
  localparam int unsigned SW = TW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]       x_q;
  logic [DEG*N-1:0]   coef_q;  // c[DEG] goes straight into acc, so only c[DEG-1:0] is kept
  logic [N-1:0]       acc_q;
  logic [KW-1:0]      k_q;
  logic [CW-1:0]      cnt_q;
  logic [2*N-1:0]     p_q;

  logic [N-1:0]       coef_sel;
  logic [2*N:0]       p_adj;
  logic [TW-1:0]      t;
  logic [SW-1:0]      s;
  logic               sat;
  logic [N-1:0]       acc_d;

  always_comb begin
    coef_sel = '0;
    for (int unsigned i = 0; i < DEG; i++) begin
      if (k_q == KW'(i + 1)) coef_sel = coef_q[i*N +: N];
    end
  end

`ifdef HORNER_ROUND_EN
  localparam logic [2*N:0] HALF = (2*N+1)'(1) << (FRAC - 1);
  assign p_adj = {1'b0, p_q} + HALF;
`else
  assign p_adj = {1'b0, p_q};
`endif

  assign t     = TW'(p_adj >> FRAC);
  assign s     = {1'b0, t} + SW'(coef_sel);
  assign sat   = |s[SW-1:N];
  assign acc_d = sat ? '1 : s[N-1:0];

  always_ff @(negedge clkn_i) begin
    if (rstn_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req.start_i) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_ACC;
      S_ACC:   state_d = (k_q == KW'(1)) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req.busy_o = (state_q != S_IDLE);

  always_ff @(negedge clkn_i) begin
    if (rstn_i) begin
      x_q        <= '0;
      coef_q     <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      p_q        <= '0;
      mul_a_o    <= '0;
      mul_b_o    <= '0;
      req.y_o    <= '0;
      req.done_o <= 1'b0;
      req.ovf_o  <= 1'b0;
    end else begin
      req.done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req.start_i) begin
            x_q       <= req.x_i;
            coef_q    <= req.coef_i[DEG*N-1:0];
            acc_q     <= req.coef_i[DEG*N +: N];
            k_q       <= KW'(DEG);
            req.ovf_o <= 1'b0;
          end
        end
        S_ISSUE: begin
          mul_a_o <= acc_q;
          mul_b_o <= x_q;
          cnt_q   <= CW'(MUL_LAT);
        end
        S_WAIT: begin
          if (cnt_q == '0) p_q   <= mul_p_i;
          else             cnt_q <= cnt_q - CW'(1);
        end
        S_ACC: begin
          acc_q <= acc_d;
          k_q   <= k_q - KW'(1);
          if (sat) req.ovf_o <= 1'b1;
          // The result register is loaded on entry to DONE so done_o and y_o change together.
          if (k_q == KW'(1)) begin
            req.y_o    <= acc_d;
            req.done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_horner_poly_seq.sv
// Directed self-checking bench for horner_poly_seq with a 4-stage multiplier model.
module tb_horner_poly_seq;

  localparam int unsigned N       = 13;
  localparam int unsigned DEG     = 3;
  localparam int unsigned FRAC    = 10;
  localparam int unsigned MUL_LAT = 4;
  localparam int          LAT_EXP = DEG * (MUL_LAT + 3) + 1;

`ifdef HORNER_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clkn;
  logic          rstn;
  logic [N-1:0]  mul_a;
  logic [N-1:0]  mul_b;
  logic [2*N-1:0] mul_p;
  logic [2*N-1:0] mp [4];

  int checks = 0;
  int errors = 0;

  horner_poly_seq_if #(.N(N), .DEG(DEG)) bus ();

  horner_poly_seq #(
    .N(N), .DEG(DEG), .FRAC(FRAC), .MUL_LAT(MUL_LAT)
  ) dut (
    .clkn_i  (clkn),
    .rstn_i  (rstn),
    .req     (bus),
    .mul_a_o (mul_a),
    .mul_b_o (mul_b),
    .mul_p_i (mul_p)
  );

  initial clkn = 1'b1;
  always #5 clkn = ~clkn;

  always @(negedge clkn) begin
    mp[0] <= mul_a * mul_b;
    mp[1] <= mp[0];
    mp[2] <= mp[1];
    mp[3] <= mp[2];
  end
  assign mul_p = mp[3];

  typedef struct {
    string       name;
    logic [12:0] x;
    logic [12:0] c3, c2, c1, c0;
    logic [12:0] y;
    logic        ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_eval(input logic [12:0] x, input logic [51:0] coef,
                          output int lat, output logic bviol);
    lat   = -1;
    bviol = 1'b0;
    bus.start_i = 1'b1;
    bus.x_i     = x;
    bus.coef_i  = coef;
    @(negedge clkn); #1;
    bus.start_i = 1'b0;
    bus.x_i     = ~x;
    bus.coef_i  = ~coef;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clkn); #1;
      if (mul_b !== x) bviol = 1'b1;
      if (bus.done_o === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic        bviol;
    int          dones;
    int          last_done;
    logic [12:0] exp_y;

    vecs[0]  = '{"identity",   13'd1024, 13'd1024, 13'd1024, 13'd1024, 13'd1024, 13'd4096, 1'b0};
    vecs[1]  = '{"round_half", 13'd512,  13'd1,    13'd0,    13'd0,    13'd0,    RND ? 13'd1 : 13'd0, 1'b0};
    vecs[2]  = '{"saturate",   13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd8191, 1'b1};
    vecs[3]  = '{"ovf_clear",  13'd0,    13'd8191, 13'd8191, 13'd8191, 13'd5,    13'd5,    1'b0};
    vecs[4]  = '{"zero_point", 13'd0,    13'd5,    13'd5,    13'd5,    13'd77,   13'd77,   1'b0};
    vecs[5]  = '{"x2_linear",  13'd2048, 13'd0,    13'd0,    13'd1024, 13'd1024, 13'd3072, 1'b0};
    vecs[6]  = '{"cube_1p5",   13'd1536, 13'd1024, 13'd0,    13'd0,    13'd0,    13'd3456, 1'b0};
    vecs[7]  = '{"small_x",    13'd3,    13'd0,    13'd0,    13'd1000, 13'd7,    RND ? 13'd10 : 13'd9, 1'b0};
    vecs[8]  = '{"max_exact",  13'd1024, 13'd0,    13'd0,    13'd0,    13'd8191, 13'd8191, 1'b0};
    vecs[9]  = '{"max_plus1",  13'd1024, 13'd0,    13'd0,    13'd1,    13'd8191, 13'd8191, 1'b1};
    vecs[10] = '{"mixed",      13'd1100, 13'd100,  13'd200,  13'd300,  13'd400,  RND ? 13'd1077 : 13'd1075, 1'b0};

    rstn        = 1'b1;
    bus.start_i = 1'b0;
    bus.x_i     = '0;
    bus.coef_i  = '0;
    repeat (3) @(negedge clkn);
    #1;
    rstn = 1'b0;
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_y",    bus.y_o,    0);
    check("rst_ovf",  bus.ovf_o,  0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);

    for (int i = 0; i < 11; i++) begin
      run_eval(vecs[i].x, {vecs[i].c3, vecs[i].c2, vecs[i].c1, vecs[i].c0}, lat, bviol);
      check({vecs[i].name, "_latency"}, lat, LAT_EXP);
      check({vecs[i].name, "_y"},       bus.y_o,  vecs[i].y);
      check({vecs[i].name, "_ovf"},     bus.ovf_o, vecs[i].ovf);
      check({vecs[i].name, "_mul_b"},   bviol, 0);
      @(negedge clkn); #1;
      check({vecs[i].name, "_done_pulse"}, bus.done_o, 0);
      check({vecs[i].name, "_idle"},       bus.busy_o, 0);
    end

    // start held high with x_i changing every cycle; result y = x (c1 = 1.0)
    dones     = 0;
    last_done = -1;
    bus.coef_i = {13'd0, 13'd0, 13'd1024, 13'd0};
    for (int cyc = 0; cyc < 70; cyc++) begin
      bus.start_i = 1'b1;
      bus.x_i     = 13'(100 + 3*cyc);
      @(negedge clkn); #1;
      if (bus.done_o === 1'b1) begin
        dones++;
        exp_y = 13'(100 + 3*(cyc - 21));
        check("busy_rej_y", bus.y_o, exp_y);
        if (last_done >= 0) check("busy_rej_spacing", cyc - last_done, 23);
        last_done = cyc;
      end
    end
    bus.start_i = 1'b0;
    check("busy_rej_count", dones, 3);
    for (int n = 0; n < 40; n++) begin
      @(negedge clkn); #1;
      if (bus.busy_o === 1'b0) break;
    end
    check("busy_rej_drain", bus.busy_o, 0);

    // reset asserted during the second WAIT
    bus.start_i = 1'b1;
    bus.x_i     = 13'd1024;
    bus.coef_i  = {4{13'd1024}};
    @(negedge clkn); #1;
    bus.start_i = 1'b0;
    repeat (9) @(negedge clkn);
    #1;
    check("midrst_pre_mul_a", mul_a, 2048);
    check("midrst_pre_busy", bus.busy_o, 1);
    rstn = 1'b1;
    @(negedge clkn); #1;
    rstn = 1'b0;
    check("midrst_busy",  bus.busy_o, 0);
    check("midrst_y",     bus.y_o,    0);
    check("midrst_mul_a", mul_a,      0);
    check("midrst_ovf",   bus.ovf_o,  0);
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clkn); #1;
      if (bus.done_o === 1'b1) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_eval(13'd1024, {4{13'd1024}}, lat, bviol);
    check("midrst_fresh_latency", lat, LAT_EXP);
    check("midrst_fresh_y", bus.y_o, 4096);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/horner_poly_seq.md
# horner_poly_seq

Horner-scheme polynomial evaluator that sequences the 13×13 radix-4 Booth multiplier in the non-linear approximation datapath. It computes y = c[DEG]·x^DEG + … + c[1]·x + c[0] in unsigned fixed point. It drives the multiplier operands and consumes its product after the multiplier's fixed pipeline latency. It applies rounding or truncation and saturation between iterations, and returns one N-bit result per request.

## Interface
- N, default 13: operand, coefficient and result width; must equal the multiplier's N.
- DEG, default 3: polynomial degree; DEG ≥ 1.
- FRAC, default 10: fractional bits of x, coefficients and y (unsigned Q(N-FRAC).FRAC); 1 ≤ FRAC < N.
- MUL_LAT, default 4: multiplier latency in clocks from operands stable to product valid.

Ports:
- clkn_i  in  1  sole clock; all registers update on its falling edge, matching the multiplier.
- rstn_i  in  1  reset, synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- x_i  in  N  evaluation point; latched on accepted start.
- coef_i  in  (DEG+1)*N  packed coefficients, c[k] = coef_i[k*N +: N]; latched on accepted start.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when y_o is updated.
- y_o  out  N  result; holds until next done_o.
- ovf_o  out  1  sticky saturation flag for the current/last evaluation; cleared on accepted start.
- mul_a_o  out  N  multiplicand to multiplier (registered).
- mul_b_o  out  N  multiplier operand to multiplier (registered).
- mul_p_i  in  2N  product from multiplier.

## Operation
- States: IDLE, ISSUE, WAIT, ACC, DONE.
- IDLE: on start_i=1, latch x and all coefficients, set acc=c[DEG], k=DEG, clear ovf_o, go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): register mul_a_o=acc and mul_b_o=x, load wait counter with MUL_LAT, go to WAIT. Both operands stay constant through WAIT.
- WAIT (MUL_LAT+1 cycles): decrement the counter. On the cycle the counter is 0, register p=mul_p_i and go to ACC.
- ACC (1 cycle):
  - With rounding: t = (p + 2^(FRAC-1)) >> FRAC.
  - Without rounding: t = p >> FRAC.
  - t is held in 2N-FRAC+1 bits.
  - s = t + c[k-1].
  - If s > 2^N-1: acc = 2^N-1 and ovf_o = 1. Otherwise acc = s[N-1:0].
  - k = k-1. If k==0 go to DONE, else go to ISSUE.
- DONE (1 cycle): y_o=acc, done_o=1, go to IDLE.
- start_i while busy_o=1 is ignored. No queuing.
- Inputs x_i and coef_i may change freely after acceptance.
- Reset at any time: state IDLE. busy_o=0, done_o=0, y_o=0, ovf_o=0, mul_a_o=0, mul_b_o=0. Internal acc, k and counter are cleared. An in-flight evaluation is discarded and produces no done_o.

## Timing
- Each iteration takes MUL_LAT+3 cycles (ISSUE 1, WAIT MUL_LAT+1, ACC 1).
- Start accepted at edge e0. done_o is high in cycle DEG·(MUL_LAT+3)+1 after e0; this is 22 for the defaults.
- busy_o rises the cycle after e0 and falls when returning to IDLE after DONE.
- Throughput: a new start is accepted no sooner than the cycle after done_o. Back-to-back gap: one IDLE cycle.
- The product is sampled MUL_LAT+1 cycles after operands change, giving one cycle of margin over the multiplier's 4-stage path.

## Configuration
- HORNER_ROUND_EN defined: round half-up at the FRAC shift as specified above.
- HORNER_ROUND_EN undefined: truncate (t = p >> FRAC). No rounding adder is instantiated.
- Latency, saturation and handshake are identical in both builds.

## Test plan
- Identity: x=1024, c3=c2=c1=c0=1024 → y_o=4096, ovf_o=0, done_o pulse exactly 22 cycles after start edge.
- Rounding: x=512, c3=1, c2=c1=c0=0 → y_o=1 with HORNER_ROUND_EN; y_o=0 without.
- Saturation: x=8191, all coefficients 8191 → y_o=8191, ovf_o=1. Then x=0, c0=5 → y_o=5, ovf_o=0.
- Zero point: x=0, c3=c2=c1=5, c0=77 → y_o=77, mul_b_o=0 during every WAIT.
- Busy rejection: start_i held high for the whole evaluation with changing x_i → exactly one done_o per 23 cycles. The result reflects the x_i latched at each acceptance.
- Reset mid-op: assert rstn_i=1 for 1 cycle during the second WAIT → next cycle busy_o=0, y_o=0, mul_a_o=0. No done_o follows. A fresh start then completes normally in 22 cycles.
